traffic_request_latch: RTL
==========================

// Module: traffic_request_latch
// PURPOSE
//  Upstream conditioning stage for traffic_light_controller. Synchronises and
//  debounces the four raw lane sensors (W, EL, NL, E), then latches a vehicle
//  request per lane. Each request holds until the controller reports that lane
//  served. Outputs a clean pending-request vector plus oldest-lane and
//  starvation hints that the controller uses when it picks the next phase.
// PARAMETERS
//  DEB_CYCLES  3   consecutive clks a synced sensor must differ from the debounced state before it is accepted (>=1)
//  AGE_W       4   width of the per-lane wait-age counter
//  STARVE_LIM  10  age at which a pending lane is flagged starved (< 2**AGE_W)
// PORTS
//  clk            in   1  system clock, rising edge
//  sys_reset      in   1  asynchronous, active-low reset
//  sensor_in      in   4  raw sensors: [0]=W [1]=EL [2]=NL [3]=E
//  serve          in   4  from controller; bit i high while lane i has green
//  req_pending    out  4  latched requests, registered
//  req_any        out  1  |req_pending
//  new_req_pulse  out  4  1-clk pulse on the cycle req_pending[i] goes 0->1
//  oldest_lane    out  2  index of the selected pending lane; 0 when none pending
//  starve         out  4  pending lane whose age >= STARVE_LIM
// BEHAVIOUR
//  - Reset (sys_reset=0, async): sync flops, debounce state and counters,
//    req_pending, age and new_req_pulse all cleared to 0; all outputs read 0.
//    Takes effect immediately, including mid-debounce or mid-count.
//  - Sync: 2-flop synchroniser per lane (s1 -> s2).
//  - Debounce, per lane, counter width $clog2(DEB_CYCLES+1):
//    - s2==deb: cnt<=0.
//    - s2!=deb and cnt==DEB_CYCLES-1: deb<=s2, cnt<=0.
//    - otherwise: cnt<=cnt+1.
//    - Any glitch back to deb restarts the count.
//  - Latch: req_pending[i] <= serve[i] ? 0 : (req_pending[i] | deb[i]).
//    - serve wins over a simultaneous set.
//    - A car still present after serve drops re-latches on the next clk.
//  - Latency: req_pending rises at the (DEB_CYCLES+3)th rising edge, counting
//    the first edge that samples sensor_in high. DEB_CYCLES=3 gives the 6th edge.
//  - new_req_pulse[i] = req_pending[i] & ~req_pending_q[i]. Registered delay
//    flop; the pulse is high for exactly one clk.
//  - serve is multi-hot tolerant: every served lane clears.
// CONFIGURATION
//  TRAFFIC_STARVE_EN defined:
//    - Per-lane age counter: 0 while not pending or serve[i]=1; +1 per clk
//      while pending; saturates at 2**AGE_W-1, no wrap.
//    - starve[i] = req_pending[i] & (age[i] >= STARVE_LIM).
//    - oldest_lane = pending lane with max age; ties go to the lowest index.
//  TRAFFIC_STARVE_EN undefined:
//    - No age counters; starve = 4'b0.
//    - oldest_lane = lowest-index pending lane (fixed priority W>EL>NL>E).
//  Both builds: oldest_lane is combinational from registers, with no added latency.
// TESTING
//  1. Hold sensor_in=4'b0001 from edge 0, DEB_CYCLES=3 -> req_pending=0001 after edge 5; new_req_pulse[0] high 1 clk.
//  2. Pulse sensor_in[2] high for 2 clks only -> req_pending stays 0000, new_req_pulse never fires.
//  3. req_pending=0010, assert serve=0010 with sensor_in[1] low -> req_pending=0000 next edge; serve and a fresh deb set in the same clk -> stays 0.
//  4. STARVE_EN: latch lane 3, no serve for 10 clks -> starve=1000. Hold for 20 clks -> age stays 15, no wrap. Latch lane 0 later -> oldest_lane=3.
//  5. No STARVE_EN: req_pending=1100 -> oldest_lane=2, starve=0000. req_pending=0000 -> oldest_lane=0, req_any=0.
//  6. Drop sys_reset mid-debounce with req_pending=1111 -> all outputs 0 immediately. On release with sensors low, they stay 0.

Source files
------------

// File: rtl/traffic_request_latch.sv
// Sensor conditioning ahead of traffic_light_controller: sync, debounce and latch per-lane requests.
// Optional age/starvation tracking is enabled by defining TRAFFIC_STARVE_EN.
module traffic_request_latch #(
  parameter int unsigned DEB_CYCLES = 3,
  parameter int unsigned AGE_W      = 4,
  parameter int unsigned STARVE_LIM = 10
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic [3:0] sensor_in,
  input  logic [3:0] serve,
  output logic [3:0] req_pending,
  output logic       req_any,
  output logic [3:0] new_req_pulse,
  output logic [1:0] oldest_lane,
  output logic [3:0] starve
);

  localparam int unsigned LANES = 4;
  localparam int unsigned CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  // Elaboration guard on parameter ranges
  if (DEB_CYCLES < 1 || STARVE_LIM >= (1 << AGE_W)) begin : g_bad_cfg
    $error("traffic_request_latch: illegal DEB_CYCLES/AGE_W/STARVE_LIM");
  end

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [3:0]       deb;
  logic [3:0]       req_pending_q;
  logic [CNT_W-1:0] cnt [LANES];

  // Synchroniser, debounce, request latch and edge-detect delay flop
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      s1            <= '0;
      s2            <= '0;
      deb           <= '0;
      req_pending   <= '0;
      req_pending_q <= '0;
      for (int i = 0; i < LANES; i++) cnt[i] <= '0;
    end else begin
      s1            <= sensor_in;
      s2            <= s1;
      req_pending   <= ~serve & (req_pending | deb);
      req_pending_q <= req_pending;
      for (int i = 0; i < LANES; i++) begin
        if (s2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          deb[i] <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign req_any       = |req_pending;
  assign new_req_pulse = req_pending & ~req_pending_q;

`ifdef TRAFFIC_STARVE_EN
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};
  localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIM);

  logic [AGE_W-1:0] age [LANES];
  logic [AGE_W-1:0] best_age;
  logic             found;

  // Saturating wait-age per lane, cleared when idle or served
  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      for (int i = 0; i < LANES; i++) age[i] <= '0;
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (!req_pending[i] || serve[i]) age[i] <= '0;
        else if (age[i] != AGE_MAX)      age[i] <= age[i] + AGE_W'(1);
      end
    end
  end

  // Oldest pending lane; strict compare keeps ties on the lowest index
  always_comb begin
    oldest_lane = '0;
    best_age    = '0;
    found       = 1'b0;
    starve      = '0;
    for (int i = 0; i < LANES; i++) begin
      starve[i] = req_pending[i] & (age[i] >= AGE_LIM);
      if (req_pending[i] && (!found || age[i] > best_age)) begin
        oldest_lane = 2'(i);
        best_age    = age[i];
        found       = 1'b1;
      end
    end
  end
`else
  // Fixed priority W > EL > NL > E
  always_comb begin
    oldest_lane = '0;
    starve      = '0;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (req_pending[i]) oldest_lane = 2'(i);
    end
  end
`endif

endmodule
